// File: rtl/fifo_prog.sv
// fifo_prog: parametrised synchronous FIFO with full-range fill count,
// programmable almost-full/almost-empty thresholds, standard or FWFT read
// mode, synchronous flush and sticky overflow/underflow flags.
module fifo_prog #(
  parameter int WORD     = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       clr_err_i,
  input  logic                       wr_i,
  input  logic [WORD-1:0]            data_i,
  input  logic                       rd_i,
  output logic [WORD-1:0]            data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] AF_TH = FW'(AF_LEVEL);
  localparam logic [FW-1:0] AE_TH = FW'(AE_LEVEL);
  localparam logic [FW-1:0] FULL_TH = FW'(DEPTH);

  // Illegal geometry or thresholds stop elaboration.
  if ((WORD < 1) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AF_LEVEL < 1) || (AF_LEVEL > DEPTH) ||
      (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1) ||
      ((FWFT != 0) && (FWFT != 1))) begin : g_param_check
    $error("fifo_prog: illegal DEPTH, WORD, FWFT or threshold parameter");
  end

  logic [WORD-1:0] mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [FW-1:0]   fill_r;
  logic [FW-1:0]   fill_nxt_s;
  logic            full_r;
  logic            empty_r;
  logic            af_r;
  logic            ae_r;
  logic            ovf_r;
  logic            udf_r;
  logic [WORD-1:0] data_r;
  logic            valid_r;

  logic wr_acc_s;
  logic rd_acc_s;
  logic ovf_set_s;
  logic udf_set_s;

  // Acceptance and error detection; flush masks both requests and errors.
  always_comb begin
    wr_acc_s  = wr_i & ~full_r  & ~flush_i;
    rd_acc_s  = rd_i & ~empty_r & ~flush_i;
    ovf_set_s = wr_i & full_r   & ~flush_i;
    udf_set_s = rd_i & empty_r  & ~flush_i;
  end

  // Next fill value: flush clears, single-sided access steps by one.
  always_comb begin
    fill_nxt_s = fill_r;
    if (flush_i) begin
      fill_nxt_s = {FW{1'b0}};
    end else if (wr_acc_s && !rd_acc_s) begin
      fill_nxt_s = fill_r + FW'(1'b1);
    end else if (rd_acc_s && !wr_acc_s) begin
      fill_nxt_s = fill_r - FW'(1'b1);
    end else begin
      fill_nxt_s = fill_r;
    end
  end

  // Storage array: written only on an accepted write, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Pointers, fill count and status flags derived from the next fill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= {FW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
    end else begin
      if (flush_i) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1'b1);
        end
        if (rd_acc_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1'b1);
        end
      end
      fill_r  <= fill_nxt_s;
      full_r  <= (fill_nxt_s == FULL_TH);
      empty_r <= (fill_nxt_s == {FW{1'b0}});
      af_r    <= (fill_nxt_s >= AF_TH);
      ae_r    <= (fill_nxt_s <= AE_TH);
    end
  end

  // Sticky error flags; a new error wins over a coincident clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_set_s | (ovf_r & ~clr_err_i);
      udf_r <= udf_set_s | (udf_r & ~clr_err_i);
    end
  end

  // Standard-mode read register and one-cycle valid pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_r  <= {WORD{1'b0}};
      valid_r <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        data_r <= mem_r[rd_ptr_r];
      end
      valid_r <= rd_acc_s;
    end
  end

  if (FWFT == 1) begin : g_fwft
    // Head entry presented directly; zero while empty so reset shows 0.
    always_comb begin
      if (empty_r) begin
        data_o = {WORD{1'b0}};
      end else begin
        data_o = mem_r[rd_ptr_r];
      end
      valid_o = ~empty_r;
    end
  end else begin : g_std
    // Registered read data and pulse.
    always_comb begin
      data_o  = data_r;
      valid_o = valid_r;
    end
  end

  assign full_o         = full_r;
  assign empty_o        = empty_r;
  assign almost_full_o  = af_r;
  assign almost_empty_o = ae_r;
  assign fill_o         = fill_r;
  assign overflow_o     = ovf_r;
  assign underflow_o    = udf_r;

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: one standard-mode and one FWFT instance.
module tb_fifo_prog;

  logic clk;
  logic rst;

  // standard-mode instance signals
  logic       s_flush, s_clr, s_wr, s_rd;
  logic [7:0] s_din, s_dout;
  logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [4:0] s_fill;

  // FWFT instance signals
  logic       f_flush, f_clr, f_wr, f_rd;
  logic [7:0] f_din, f_dout;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_fill;

  int n_checks;
  int n_errors;

  fifo_prog #(.WORD(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_std (
    .clk_i(clk), .rst_i(rst), .flush_i(s_flush), .clr_err_i(s_clr),
    .wr_i(s_wr), .data_i(s_din), .rd_i(s_rd), .data_o(s_dout),
    .valid_o(s_valid), .full_o(s_full), .empty_o(s_empty),
    .almost_full_o(s_af), .almost_empty_o(s_ae), .fill_o(s_fill),
    .overflow_o(s_ovf), .underflow_o(s_udf)
  );

  fifo_prog #(.WORD(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) u_fwft (
    .clk_i(clk), .rst_i(rst), .flush_i(f_flush), .clr_err_i(f_clr),
    .wr_i(f_wr), .data_i(f_din), .rd_i(f_rd), .data_o(f_dout),
    .valid_o(f_valid), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_af), .almost_empty_o(f_ae), .fill_o(f_fill),
    .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_std_reset();
    check("rst_fill",  32'(s_fill),  32'd0);
    check("rst_empty", 32'(s_empty), 32'd1);
    check("rst_full",  32'(s_full),  32'd0);
    check("rst_af",    32'(s_af),    32'd0);
    check("rst_ae",    32'(s_ae),    32'd1);
    check("rst_ovf",   32'(s_ovf),   32'd0);
    check("rst_udf",   32'(s_udf),   32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_data",  32'(s_dout),  32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    s_flush = 1'b0; s_clr = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
    f_flush = 1'b0; f_clr = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
    #3;
    check_std_reset();
    check("rst_f_valid", 32'(f_valid), 32'd0);
    check("rst_f_data",  32'(f_dout),  32'd0);
    tick();
    rst = 1'b0;
    tick();

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      s_wr = 1'b1; s_din = 8'(i);
      tick();
      check("wr_fill",  32'(s_fill),  32'(i + 1));
      check("wr_af",    32'(s_af),    32'((i + 1) >= 12));
      check("wr_full",  32'(s_full),  32'((i + 1) == 16));
      check("wr_ae",    32'(s_ae),    32'((i + 1) <= 2));
      check("wr_empty", 32'(s_empty), 32'd0);
    end
    s_din = 8'hAA;
    tick();
    s_wr = 1'b0;
    check("ovf_set",  32'(s_ovf),  32'd1);
    check("ovf_fill", 32'(s_fill), 32'd16);
    check("ovf_full", 32'(s_full), 32'd1);

    // drain, each read followed by an idle cycle
    for (int i = 0; i < 16; i++) begin
      s_rd = 1'b1;
      tick();
      s_rd = 1'b0;
      check("rd_valid", 32'(s_valid), 32'd1);
      check("rd_data",  32'(s_dout),  32'(i));
      check("rd_fill",  32'(s_fill),  32'(15 - i));
      check("rd_ae",    32'(s_ae),    32'((15 - i) <= 2));
      check("rd_af",    32'(s_af),    32'((15 - i) >= 12));
      check("rd_empty", 32'(s_empty), 32'((15 - i) == 0));
      tick();
      check("rd_pulse", 32'(s_valid), 32'd0);
      check("rd_hold",  32'(s_dout),  32'(i));
    end
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    check("udf_set",   32'(s_udf),   32'd1);
    check("udf_valid", 32'(s_valid), 32'd0);
    check("udf_fill",  32'(s_fill),  32'd0);
    check("ovf_keep",  32'(s_ovf),   32'd1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check("clr_ovf", 32'(s_ovf), 32'd0);
    check("clr_udf", 32'(s_udf), 32'd0);
    // clear coinciding with a new underflow: set wins
    s_clr = 1'b1; s_rd = 1'b1;
    tick();
    s_clr = 1'b0; s_rd = 1'b0;
    check("set_wins", 32'(s_udf), 32'd1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check("clr_udf2", 32'(s_udf), 32'd0);

    // fill to 5, then simultaneous access across the pointer wrap
    for (int i = 0; i < 5; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h10 + i);
      tick();
    end
    check("pre_fill", 32'(s_fill), 32'd5);
    for (int k = 0; k < 20; k++) begin
      s_wr = 1'b1; s_rd = 1'b1; s_din = 8'(8'h20 + k);
      tick();
      check("sim_fill",  32'(s_fill),  32'd5);
      check("sim_valid", 32'(s_valid), 32'd1);
      check("sim_data",  32'(s_dout),  (k < 5) ? 32'(8'h10 + k) : 32'(8'h20 + k - 5));
      check("sim_flags", 32'({s_full, s_empty, s_af, s_ae, s_ovf, s_udf}), 32'd0);
    end
    s_wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_rd = 1'b1;
      tick();
      check("tail_data", 32'(s_dout), 32'(8'h2F + k));
      check("tail_fill", 32'(s_fill), 32'(4 - k));
    end
    s_rd = 1'b0;
    tick();

    // FWFT instance
    f_wr = 1'b1; f_din = 8'h5A;
    tick();
    f_wr = 1'b0;
    check("fw_data",  32'(f_dout),  32'h5A);
    check("fw_valid", 32'(f_valid), 32'd1);
    tick();
    check("fw_hold", 32'(f_dout), 32'h5A);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    check("fw_pop_valid", 32'(f_valid), 32'd0);
    check("fw_pop_empty", 32'(f_empty), 32'd1);
    check("fw_udf",       32'(f_udf),   32'd0);
    f_wr = 1'b1; f_din = 8'hA1;
    tick();
    f_din = 8'hB2;
    tick();
    f_wr = 1'b0;
    check("fw_head1", 32'(f_dout), 32'hA1);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    check("fw_head2", 32'(f_dout), 32'hB2);
    check("fw_fill",  32'(f_fill), 32'd1);

    // flush with 9 entries and coincident wr/rd
    for (int i = 0; i < 9; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h40 + i);
      tick();
    end
    check("fl_pre", 32'(s_fill), 32'd9);
    s_flush = 1'b1; s_wr = 1'b1; s_rd = 1'b1;
    tick();
    check("fl_fill",  32'(s_fill),  32'd0);
    check("fl_empty", 32'(s_empty), 32'd1);
    check("fl_ae",    32'(s_ae),    32'd1);
    check("fl_valid", 32'(s_valid), 32'd0);
    check("fl_err",   32'({s_ovf, s_udf}), 32'd0);
    // flush again while empty with a read pending: no underflow
    tick();
    check("fl_no_udf", 32'(s_udf), 32'd0);
    s_flush = 1'b0; s_rd = 1'b0; s_din = 8'h33;
    tick();
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    check("fl_rt_data",  32'(s_dout),  32'h33);
    check("fl_rt_valid", 32'(s_valid), 32'd1);
    check("fl_rt_fill",  32'(s_fill),  32'd0);

    // asynchronous reset between edges with 7 entries stored
    for (int i = 0; i < 8; i++) begin
      s_wr = 1'b1; s_din = 8'(8'h60 + i);
      tick();
    end
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    check("ar_pre_fill",  32'(s_fill),  32'd7);
    check("ar_pre_valid", 32'(s_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_std_reset();
    tick();
    rst = 1'b0;
    s_wr = 1'b1; s_din = 8'h77;
    tick();
    s_wr = 1'b0;
    check("ar_post_fill", 32'(s_fill), 32'd1);
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    check("ar_post_data", 32'(s_dout), 32'h77);
    check("ar_post_empty", 32'(s_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
- Parametrised synchronous FIFO; successor to the basic UART byte FIFO, for use as the UART TX/RX buffer.
- Adds the following over the basic FIFO:
  - a full-range fill count (0..DEPTH inclusive);
  - programmable almost-full and almost-empty thresholds;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - synchronous flush;
  - sticky overflow and underflow error flags.

Parameters:
- WORD, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries; must be a power of two, ≥2.
- FWFT, 0: read mode.
  - 0: standard mode; data appears one cycle after an accepted read.
  - 1: FWFT mode; the head entry is presented on data_o whenever the FIFO is not empty.
- AF_LEVEL, DEPTH-4: almost_full_o asserts when fill ≥ AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty_o asserts when fill ≤ AE_LEVEL. Range 0..DEPTH-1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous clear of FIFO contents.
- clr_err_i  in  1  synchronous clear of the sticky error flags.
- wr_i  in  1  write request.
- data_i  in  WORD  write data.
- rd_i  in  1  read request (standard mode) or pop (FWFT mode).
- data_o  out  WORD  read data.
- valid_o  out  1  data_o qualifier.
- full_o  out  1  fill == DEPTH.
- empty_o  out  1  fill == 0.
- almost_full_o  out  1  fill ≥ AF_LEVEL.
- almost_empty_o  out  1  fill ≤ AE_LEVEL.
- fill_o  out  $clog2(DEPTH)+1  number of stored entries.
- overflow_o  out  1  sticky: a write was attempted while full.
- underflow_o  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - pointers cleared; fill_o=0, empty_o=1, full_o=0, almost_full_o=0, almost_empty_o=1;
  - overflow_o=0, underflow_o=0, valid_o=0, data_o=0.
  - Memory contents are not reset.
  - Reset asserted mid-transfer discards all contents immediately.
- Pointers:
  - rd and wr pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Full and empty are derived from the registered fill count, never from pointer equality.
- Write acceptance:
  - A write is accepted iff wr_i=1 and full_o=0 and flush_i=0.
  - An accepted write stores data_i at wr and advances wr.
  - A write while full is dropped, leaves all state unchanged, and sets overflow_o.
- Read acceptance:
  - A read is accepted iff rd_i=1 and empty_o=0 and flush_i=0.
  - An accepted read advances rd.
  - A read while empty is ignored and sets underflow_o.
- Simultaneous accepted read and write: both pointers advance, fill is unchanged, and all flags are unchanged.
- Fill update (registered): +1 on write only, −1 on read only, 0 otherwise. It never exceeds DEPTH and never goes below 0.
- Flag timing:
  - full_o, empty_o, almost_full_o and almost_empty_o are registered, computed from the next fill value.
  - They are therefore valid in the same cycle as the fill_o they describe; there is no extra lag.
- Standard mode (FWFT=0):
  - data_o is registered; it is loaded with mem[rd] on the edge the read is accepted.
  - valid_o is a 1-cycle pulse in the cycle after each accepted read.
  - data_o holds its value otherwise.
- FWFT mode (FWFT=1):
  - data_o = mem[rd] combinationally; valid_o = ~empty_o.
  - rd_i acts as an acknowledge and pops the head.
  - A word written into an empty FIFO is visible on data_o in the cycle after the write edge.
- Flush (flush_i=1):
  - On the next edge: pointers to 0, fill_o=0, empty_o=1, full_o=0, almost flags updated for fill 0, valid_o=0.
  - Any simultaneous wr_i/rd_i is ignored and does not set the error flags.
  - Sticky error flags are unaffected by flush.
- Error flags:
  - overflow_o and underflow_o stay set until clr_err_i=1 or reset.
  - If clr_err_i coincides with a new error, the set wins.
- Write-through:
  - The memory write port writes only on an accepted write; the original FIFO's unconditional write is removed.
  - A read of the same address in the same cycle as a write returns the old content. This only occurs when the FIFO is full or empty, so it is not observable.
- Parameter check: an elaboration-time check flags an illegal DEPTH or threshold.

Test Plan:
- Reset, then write 16 words 0x00..0x0F with FWFT=0:
  - fill_o counts 1..16;
  - almost_full_o rises when fill_o=12;
  - full_o=1 at fill 16.
  - A 17th write (0xAA) sets overflow_o, and fill_o stays 16.
- Read 16 times from the full FIFO:
  - data_o yields 0x00..0x0F, each with a valid_o pulse one cycle after rd_i;
  - almost_empty_o rises at fill_o=2;
  - empty_o=1 at the end.
  - A further rd_i sets underflow_o; pulsing clr_err_i clears both error flags.
- Pointer wrap and simultaneous access:
  - Fill to 5.
  - Do 20 cycles of simultaneous wr_i/rd_i with incrementing data.
  - Required: fill_o stays 5 throughout, flags never change, and data comes out in order across the pointer wrap.
- FWFT=1:
  - Write 0x5A into the empty FIFO; data_o=0x5A and valid_o=1 the next cycle without any rd_i.
  - Assert rd_i; valid_o drops the next cycle and empty_o=1.
- Flush with 9 entries stored, asserting wr_i and rd_i in the same cycle:
  - next cycle fill_o=0, empty_o=1, no error flag set.
  - A subsequent write/read of 0x33 returns 0x33.
- Asynchronous reset asserted between clock edges with 7 entries stored:
  - outputs go to their reset values immediately, before the next clock edge.
  - After release, the FIFO operates normally from empty.
